// File: rtl/dual_rail_tx_pkg.sv
// Shared definitions for the dual-rail transmitter: rail levels, default width
// and the handshake state encodings.
package dual_rail_tx_pkg;

  localparam logic        ON       = 1'b1;
  localparam logic        OFF      = 1'b0;
  localparam int unsigned BIT_DATA = 1024;

  typedef enum logic [1:0] {
    DR_IDLE   = 2'd0,
    DR_DATA   = 2'd1,
    DR_SPACER = 2'd2
  } dr_state_t;

endpackage

// File: rtl/dual_rail_tx_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clock) begin
    if (!reset_n) sr <= '0;
    else          sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/dual_rail_tx.sv
// Clocked producer FIFO feeding a four-phase return-to-zero dual-rail token
// driver, with handshake counting and a sticky per-phase timeout.
module dual_rail_tx
  import dual_rail_tx_pkg::*;
#(
  parameter int unsigned BIT_IN      = BIT_DATA,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIT_IN-1:0] in_data,
  input  logic              ack_nxt,
  output logic [BIT_IN-1:0] xt,
  output logic [BIT_IN-1:0] xf,
  output logic              busy,
  output logic [15:0]       tx_count,
  output logic              timeout_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [BIT_IN-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [PW-1:0]     phase;
  logic              full, empty, push, pop, done, ack_s;
  dr_state_t         state, state_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (ack_nxt),
    .q       (ack_s)
  );

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = reset_n & ~full;
  // Gated on full alone so a same-cycle pop never lets a word in while full.
  assign push     = in_valid & ~full;
  assign busy     = (state != DR_IDLE) | ~empty;

  always_comb begin
    state_nxt = state;
    pop       = OFF;
    done      = OFF;
    case (state)
      DR_IDLE: begin
        if (!empty && !ack_s) begin
          state_nxt = DR_DATA;
          pop       = ON;
        end
      end
      DR_DATA: begin
        if (ack_s) state_nxt = DR_SPACER;
      end
      DR_SPACER: begin
        if (!ack_s) begin
          state_nxt = DR_IDLE;
          done      = ON;
        end
      end
      default: state_nxt = DR_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= DR_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      xt          <= '0;
      xf          <= '0;
      tx_count    <= '0;
      timeout_err <= OFF;
      phase       <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        xt <= mem[rd_ptr];
        xf <= ~mem[rd_ptr];
      end else if (state == DR_DATA && ack_s) begin
        xt <= '0;
        xf <= '0;
      end

      if (done) tx_count <= tx_count + 16'd1;

      // Phase counter restarts on every state change and saturates at TIMEOUT.
      if (state_nxt != state)
        phase <= '0;
      else if (state != DR_IDLE && phase != PW'(TIMEOUT))
        phase <= phase + 1'b1;

      if (TIMEOUT != 0 && state != DR_IDLE && state_nxt == state &&
          phase == PW'(TIMEOUT - 1))
        timeout_err <= ON;
    end
  end

endmodule

// File: tb/tb_dual_rail_tx.sv
// Self-checking bench for dual_rail_tx: scenario tasks plus randomized traffic
// against a queue-based token-order model and a delayed-ack responder.
module tb_dual_rail_tx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       ack_nxt;
  logic [7:0] xt, xf;
  logic       busy;
  logic [15:0] tx_count;
  logic       timeout_err;

  logic resp_en = 1'b0, resp_ack = 1'b0, man_ack = 1'b0;
  assign ack_nxt = resp_en ? resp_ack : man_ack;

  int unsigned n_cmp = 0, n_bad = 0, inv_bad = 0;
  int unsigned exp_tx = 0;
  logic [7:0]  exp_q[$], obs_q[$];
  logic        prev_data = 1'b0;

  dual_rail_tx #(.BIT_IN(8), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ack_nxt(ack_nxt), .xt(xt), .xf(xf), .busy(busy),
    .tx_count(tx_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Downstream layer: raises ack 3 cycles after seeing data, drops it 3 after spacer.
  initial forever begin
    @(negedge clock);
    if (!resp_en) resp_ack = 1'b0;
    else if (!resp_ack && (xt | xf) != 8'h00) begin
      repeat (3) @(negedge clock);
      if (resp_en) resp_ack = 1'b1;
    end else if (resp_ack && (xt | xf) == 8'h00) begin
      repeat (3) @(negedge clock);
      if (resp_en) resp_ack = 1'b0;
    end
  end

  // Token monitor: records every spacer->data transition and rail violations.
  always @(negedge clock) begin
    if ((xt & xf) != 8'h00) inv_bad++;
    if (reset_n && (xt | xf) != 8'h00 && !prev_data) begin
      obs_q.push_back(xt);
      if (xf !== ~xt) inv_bad++;
    end
    prev_data = ((xt | xf) != 8'h00);
  end

  task automatic push(input logic [7:0] d, output logic acc);
    in_valid = 1'b1;
    in_data  = d;
    #1 acc = in_ready;
    @(negedge clock);
    in_valid = 1'b0;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      ok = !busy && xt == 8'h00 && xf == 8'h00 && ack_nxt == 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL %s_idle_timeout busy=%b xt=%h", name, busy, xt); end
  endtask

  task automatic check_order(input string name);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL %s_token_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL %s_token[%0d] got=%h exp=%h", name, i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (tx_count !== 16'(exp_tx)) begin
      n_bad++; $display("FAIL %s_tx_count got=%0d exp=%0d", name, tx_count, exp_tx);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    exp_tx = 0;
    n_cmp++;
    if (xt !== 8'h00 || xf !== 8'h00) begin n_bad++; $display("FAIL reset_rails xt=%h xf=%h exp=00/00", xt, xf); end
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_flags in_ready=%b busy=%b exp=0/0", in_ready, busy); end
    n_cmp++;
    if (tx_count !== 16'd0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_counters tx=%0d err=%b exp=0/0", tx_count, timeout_err); end
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_single();
    logic acc;
    man_ack = 1'b0; resp_en = 1'b1;
    test_reset();
    push(8'hA5, acc);
    n_cmp++;
    if (xt !== 8'h00) begin n_bad++; $display("FAIL single_latency_early xt=%h exp=00", xt); end
    @(negedge clock);
    n_cmp++;
    if (xt !== 8'hA5 || xf !== 8'h5A) begin n_bad++; $display("FAIL single_token xt=%h xf=%h exp=A5/5A", xt, xf); end
    exp_tx++;
    wait_idle("single");
    check_order("single");
  endtask

  task automatic test_backpressure();
    logic acc;
    int unsigned n_acc = 0;
    resp_en = 1'b0; man_ack = 1'b0;
    test_reset();
    for (int i = 0; i < 6; i++) begin
      push(8'(8'h10 + i), acc);
      if (acc) n_acc++;
    end
    n_cmp++;
    if (n_acc !== 5) begin n_bad++; $display("FAIL bp_accepted got=%0d exp=5", n_acc); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    n_cmp++;
    if (xt !== 8'h10) begin n_bad++; $display("FAIL bp_data_held xt=%h exp=10", xt); end
    resp_en = 1'b1;
    exp_tx += 5;
    wait_idle("bp");
    check_order("bp");
  endtask

  task automatic test_ack_high_start();
    logic acc, stayed = 1'b1, seen = 1'b0;
    resp_en = 1'b0; man_ack = 1'b1;
    test_reset();
    repeat (2) @(negedge clock);
    push(8'h3C, acc);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (xt !== 8'h00 || xf !== 8'h00) stayed = 1'b0;
    end
    n_cmp++;
    if (stayed !== 1'b1) begin n_bad++; $display("FAIL ackhi_spacer_held xt=%h xf=%h exp=00/00", xt, xf); end
    man_ack = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      seen = (xt != 8'h00);
    end
    n_cmp++;
    if (xt !== 8'h3C || xf !== 8'hC3) begin n_bad++; $display("FAIL ackhi_token xt=%h xf=%h exp=3C/C3", xt, xf); end
    resp_en = 1'b1;
    exp_tx++;
    wait_idle("ackhi");
    check_order("ackhi");
  endtask

  task automatic test_timeout();
    logic acc, gone = 1'b0;
    resp_en = 1'b0; man_ack = 1'b0;
    test_reset();
    push(8'hA5, acc);
    @(negedge clock);
    repeat (15) @(negedge clock);
    n_cmp++;
    if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_early got=%b exp=0", timeout_err); end
    @(negedge clock);
    n_cmp++;
    if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_flag got=%b exp=1", timeout_err); end
    n_cmp++;
    if (xt !== 8'hA5 || xf !== 8'h5A) begin n_bad++; $display("FAIL to_data_held xt=%h xf=%h exp=A5/5A", xt, xf); end
    man_ack = 1'b1;
    for (int i = 0; i < 10 && !gone; i++) begin
      @(negedge clock);
      gone = (xt == 8'h00 && xf == 8'h00);
    end
    man_ack = 1'b0;
    exp_tx++;
    wait_idle("to");
    check_order("to");
    n_cmp++;
    if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
  endtask

  task automatic test_random();
    logic acc;
    logic [7:0] w;
    man_ack = 1'b0; resp_en = 1'b1;
    test_reset();
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      w = 8'($urandom_range(0, 255));
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) push(w, acc);
      if (acc) exp_tx++;
    end
    wait_idle("rand");
    check_order("rand");
    n_cmp++;
    if (inv_bad !== 0) begin n_bad++; $display("FAIL rail_invariant violations=%0d exp=0", inv_bad); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    logic clean = 1'b1;
    resp_en = 1'b0; man_ack = 1'b0;
    push(8'h81, acc);
    push(8'h42, acc);
    push(8'h24, acc);
    n_cmp++;
    if (xt !== 8'h81) begin n_bad++; $display("FAIL mid_data xt=%h exp=81", xt); end
    reset_n = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (xt !== 8'h00 || xf !== 8'h00) begin n_bad++; $display("FAIL mid_abort xt=%h xf=%h exp=00/00", xt, xf); end
    n_cmp++;
    if (busy !== 1'b0 || tx_count !== 16'd0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_state busy=%b tx=%0d rdy=%b exp=0/0/0", busy, tx_count, in_ready);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (busy || xt != 8'h00) clean = 1'b0;
    end
    n_cmp++;
    if (clean !== 1'b1) begin n_bad++; $display("FAIL mid_fifo_flushed busy=%b xt=%h exp=0/00", busy, xt); end
  endtask

  initial begin
    test_single();
    test_backpressure();
    test_ack_high_start();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

endmodule
